reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 63 ++++++
 tb/tb_reg_file_sb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with write-through bypass and per-register pending-write scoreboard
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif
`ifndef REG_FILE_WIDTH
`define REG_FILE_WIDTH 32
`endif
module reg_file_sb #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       RegW_EN,
  input  logic [`ADDR_WIDTH-1:0]     addrD,
  input  logic [`REG_FILE_WIDTH-1:0] WriteData,
  input  logic [`ADDR_WIDTH-1:0]     addrA,
  input  logic [`ADDR_WIDTH-1:0]     addrB,
  input  logic                       useA,
  input  logic                       useB,
  input  logic                       issue_EN,
  input  logic [`ADDR_WIDTH-1:0]     issue_addr,
  output logic [`REG_FILE_WIDTH-1:0] dataA,
  output logic [`REG_FILE_WIDTH-1:0] dataB,
  output logic                       stall,
  output logic                       sb_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [`REG_FILE_WIDTH-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0] pend [NUM_REGS];
  logic wrHit, busyA, busyB, full, issueOk, underflow;
  logic [NUM_REGS-1:0] incV, decV;
  always_comb begin
    wrHit = RegW_EN && addrD != '0;
    dataA = addrA == '0 ? '0 : (wrHit && addrD == addrA) ? WriteData : regs[addrA];
    dataB = addrB == '0 ? '0 : (wrHit && addrD == addrB) ? WriteData : regs[addrB];
    // a single outstanding write retiring this cycle is satisfied by the bypass
    busyA = addrA != '0 && (pend[addrA] > 1 || (pend[addrA] == 1 && !(wrHit && addrD == addrA)));
    busyB = addrB != '0 && (pend[addrB] > 1 || (pend[addrB] == 1 && !(wrHit && addrD == addrB)));
    full = issue_EN && issue_addr != '0 && pend[issue_addr] == CNT_MAX && !(wrHit && addrD == issue_addr);
    stall = (useA && busyA) || (useB && busyB) || full;
    issueOk = issue_EN && !stall && issue_addr != '0;
    incV = issueOk ? NUM_REGS'(1) << issue_addr : '0;
    decV = wrHit ? NUM_REGS'(1) << addrD : '0;
    underflow = wrHit && pend[addrD] == '0 && !(issueOk && issue_addr == addrD);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wrHit) regs[addrD] <= WriteData;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (incV[i] && !decV[i]) pend[i] <= pend[i] + 1'b1;
        else if (decV[i] && !incV[i] && pend[i] != '0) pend[i] <= pend[i] - 1'b1;
      end
      if (underflow) sb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vectors with hand-computed expectations for reg_file_sb
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif
`ifndef REG_FILE_WIDTH
`define REG_FILE_WIDTH 32
`endif
module tb_reg_file_sb;
  logic clk = 0, reset, RegW_EN, useA, useB, issue_EN, stall, sb_err;
  logic [`ADDR_WIDTH-1:0] addrD, addrA, addrB, issue_addr;
  logic [`REG_FILE_WIDTH-1:0] WriteData, dataA, dataB;
  int total = 0, bad = 0;
  reg_file_sb dut (
    .clk(clk), .reset(reset), .RegW_EN(RegW_EN), .addrD(addrD), .WriteData(WriteData),
    .addrA(addrA), .addrB(addrB), .useA(useA), .useB(useB), .issue_EN(issue_EN),
    .issue_addr(issue_addr), .dataA(dataA), .dataB(dataB), .stall(stall), .sb_err(sb_err)
  );
  always #5 clk = ~clk;
  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task idle();
    reset = 0; RegW_EN = 0; addrD = 0; WriteData = 0; addrA = 0; addrB = 0;
    useA = 0; useB = 0; issue_EN = 0; issue_addr = 0;
  endtask
  task tick();
    @(posedge clk);
    #1;
  endtask
  task settle();
    #1;
  endtask
  initial begin
    idle();
    reset = 1;
    tick();
    tick();
    idle();
    addrA = 5; addrB = 9; settle();
    check("rst_dataA", dataA, 0);
    check("rst_dataB", dataB, 0);
    check("rst_stall", stall, 0);
    check("rst_err", sb_err, 0);
    issue_EN = 1; issue_addr = 5; settle();
    check("iss5_stall", stall, 0);
    tick();
    idle();
    RegW_EN = 1; addrD = 5; WriteData = 32'h1234; addrB = 5; useA = 1; addrA = 5; settle();
    check("byp_dataB", dataB, 32'h1234);
    check("byp_stall", stall, 0);
    tick();
    idle();
    addrA = 5; settle();
    check("rd5_dataA", dataA, 32'h1234);
    check("rd5_err", sb_err, 0);
    RegW_EN = 1; addrD = 0; WriteData = 32'hFFFF; addrA = 0; settle();
    check("r0_byp", dataA, 0);
    tick();
    idle();
    addrA = 0; useA = 1; issue_EN = 1; issue_addr = 0; settle();
    check("r0_read", dataA, 0);
    check("r0_iss_stall", stall, 0);
    tick();
    idle();
    RegW_EN = 1; addrD = 0; settle();
    tick();
    idle();
    settle();
    check("r0_no_err", sb_err, 0);
    issue_EN = 1; issue_addr = 3; settle();
    check("iss3_stall", stall, 0);
    tick();
    idle();
    useA = 1; addrA = 3; settle();
    check("busy3", stall, 1);
    useA = 0; settle();
    check("busy3_unused", stall, 0);
    useA = 1; tick();
    RegW_EN = 1; addrD = 3; WriteData = 32'hABCD; settle();
    check("wb3_stall", stall, 0);
    check("wb3_dataA", dataA, 32'hABCD);
    tick();
    idle();
    useA = 1; addrA = 3; settle();
    check("free3", stall, 0);
    check("free3_err", sb_err, 0);
    idle();
    issue_EN = 1; issue_addr = 2; tick();
    idle();
    useB = 1; addrB = 2; settle();
    check("busy2_B", stall, 1);
    idle();
    RegW_EN = 1; addrD = 2; WriteData = 32'h22; tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      issue_EN = 1; issue_addr = 7; settle();
      check("iss7_stall", stall, 0);
      tick();
    end
    settle();
    check("full7", stall, 1);
    RegW_EN = 1; addrD = 7; WriteData = 32'h7; settle();
    check("full7_wb", stall, 0);
    tick();
    idle();
    issue_EN = 1; issue_addr = 7; settle();
    check("full7_again", stall, 1);
    idle();
    useA = 1; addrA = 7; RegW_EN = 1; addrD = 7; WriteData = 32'h71; settle();
    check("busy7_p3", stall, 1);
    tick();
    settle();
    check("busy7_p2", stall, 1);
    tick();
    settle();
    check("busy7_p1_wb", stall, 0);
    check("busy7_dataA", dataA, 32'h71);
    tick();
    idle();
    useA = 1; addrA = 7; settle();
    check("free7", stall, 0);
    check("drain7_err", sb_err, 0);
    idle();
    RegW_EN = 1; addrD = 9; WriteData = 32'h99; settle();
    check("uf_pre", sb_err, 0);
    tick();
    idle();
    addrA = 9; settle();
    check("uf_set", sb_err, 1);
    check("uf_data", dataA, 32'h99);
    tick();
    tick();
    check("uf_sticky", sb_err, 1);
    issue_EN = 1; issue_addr = 4; tick();
    idle();
    reset = 1; RegW_EN = 1; addrD = 4; WriteData = 32'h44; tick();
    idle();
    addrA = 4; addrB = 5; useA = 1; settle();
    check("rst4_data", dataA, 0);
    check("rst5_data", dataB, 0);
    check("rst4_stall", stall, 0);
    check("rst4_err", sb_err, 0);
    idle();
    RegW_EN = 1; addrD = 4; WriteData = 32'h45; tick();
    idle();
    settle();
    check("post_rst_uf", sb_err, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
